// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor.
// Operands are captured on an accepted start. DIGIT bits are then processed
// per clock, LSB first. The result bits shift into sum from the MSB end, so
// after WIDTH/DIGIT cycles sum holds the full result in natural bit order.
// Subtraction is done as a + ~b + 1.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    // Reject illegal parameter combinations at elaboration time.
    if ((WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
        $error("serial_adder: WIDTH must be in the range 2..64");
    end
    if ((DIGIT < 1) ? 1'b1 : ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("serial_adder: WIDTH must be an integer multiple of DIGIT");
    end

    localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ripple-add one digit. Result packs {carry out, carry into top bit, sum bits}.
    // The carry into the top bit of the final digit is the carry into bit
    // WIDTH-1, which is what the overflow flag needs.
    function automatic logic [DIGIT+1:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c_in
    );
        logic             c;
        logic             c_top;
        logic [DIGIT-1:0] s;
        c     = c_in;
        c_top = c_in;
        s     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c_top = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_top, s};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               done_r;
    logic               ready_r;
    logic               busy_r;

    logic [DIGIT+1:0]       add_s;
    logic [WIDTH+DIGIT-1:0] cat_s;
    logic [WIDTH-1:0]       sum_next_s;

    // Digit add of the low operand bits and the shifted result word.
    always_comb begin
        add_s      = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
        cat_s      = {add_s[DIGIT-1:0], sum_r};
        sum_next_s = cat_s[WIDTH+DIGIT-1:DIGIT];
    end

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // b is inverted and the carry seeded with 1 for subtraction.
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub ? 1'b1 : cin;
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= add_s[DIGIT+1];
                    cout_r  <= add_s[DIGIT+1];
                    ovf_r   <= add_s[DIGIT+1] ^ add_s[DIGIT];
                    sum_r   <= sum_next_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign sum   = sum_r;
    assign cout  = cout_r;
    assign ovf   = ovf_r;
    assign done  = done_r;

endmodule
